// File: rtl/load_store_unit.sv
// Load/store unit: turns a datapath load/store into a word-aligned, byte-enabled req/ack bus access and stalls pc until it completes.
// At least 3 cycles (IDLE, REQ.., DONE) with REQ held until iBusAck; LSU_TIMEOUT_EN adds a TIMEOUT_CYCLES bus watchdog.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        iMemRead,
   input  logic        iMemWrite,
   input  logic [31:0] iAddress,
   input  logic [31:0] iData,
   input  logic [2:0]  iFunct3,
   output logic [31:0] oData,
   output logic        oStall,
   output logic        oMisaligned,
   output logic        oError,
   output logic        oBusReq,
   output logic        oBusWe,
   output logic [31:0] oBusAddr,
   output logic [31:0] oBusWData,
   output logic [3:0]  oBusByteEn,
   input  logic        iBusAck,
   input  logic [31:0] iBusRData
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [31:0] r_bus_addr;
   logic [31:0] r_bus_wdata;
   logic        r_bus_we;
   logic [3:0]  r_bus_byteen;
   logic [2:0]  r_funct3;
   logic [1:0]  r_lo;
   logic [31:0] r_data;

   logic        w_access;
   logic        w_is_byte;
   logic        w_is_half;
   logic        w_misaligned;
   logic [3:0]  w_byteen;
   logic [31:0] w_wdata;

   logic        w_stall;
   logic        w_mis_pulse;
   logic        w_latch;
   logic        w_complete;
   logic        w_expire;
   logic        w_timeout_hit;

   logic [7:0]  w_rbyte;
   logic [15:0] w_rhalf;
   logic [31:0] w_load_ext;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   // funct3[1:0]: 00 byte, 01 half, anything else is a word; bit 2 only selects zero-extension on loads
   assign w_access     = (iMemRead | iMemWrite) & ~reset;
   assign w_is_byte    = (iFunct3[1:0] == 2'b00);
   assign w_is_half    = (iFunct3[1:0] == 2'b01);
   assign w_misaligned = (w_is_half & iAddress[0]) |
                         (~w_is_byte & ~w_is_half & (iAddress[1:0] != 2'b00));

   always_comb begin
      w_byteen = 4'b1111;
      w_wdata  = iData;
      if (w_is_byte) begin
         w_byteen = 4'b0001 << iAddress[1:0];
         w_wdata  = {4{iData[7:0]}};
      end else if (w_is_half) begin
         w_byteen = iAddress[1] ? 4'b1100 : 4'b0011;
         w_wdata  = {2{iData[15:0]}};
      end
   end

   always_comb begin
      w_rbyte = iBusRData[7:0];
      case (r_lo)
         2'd0:    w_rbyte = iBusRData[7:0];
         2'd1:    w_rbyte = iBusRData[15:8];
         2'd2:    w_rbyte = iBusRData[23:16];
         default: w_rbyte = iBusRData[31:24];
      endcase
      w_rhalf = r_lo[1] ? iBusRData[31:16] : iBusRData[15:0];
      case (r_funct3)
         3'b000:  w_load_ext = {{24{w_rbyte[7]}}, w_rbyte};
         3'b100:  w_load_ext = {24'd0, w_rbyte};
         3'b001:  w_load_ext = {{16{w_rhalf[15]}}, w_rhalf};
         3'b101:  w_load_ext = {16'd0, w_rhalf};
         default: w_load_ext = iBusRData;
      endcase
   end

   always_comb begin
      w_next      = r_state;
      w_stall     = 1'b0;
      w_mis_pulse = 1'b0;
      w_latch     = 1'b0;
      w_complete  = 1'b0;
      w_expire    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_access) begin
               if (w_misaligned) begin
                  w_mis_pulse = 1'b1;
               end else begin
                  w_stall = 1'b1;
                  w_latch = 1'b1;
                  w_next  = S_REQ;
               end
            end
         end
         S_REQ: begin
            w_stall = 1'b1;
            // an ack arriving on the expiry cycle still completes normally
            if (iBusAck) begin
               w_complete = 1'b1;
               w_next     = S_DONE;
            end else if (w_timeout_hit) begin
               w_expire = 1'b1;
               w_next   = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_bus_addr   <= '0;
         r_bus_wdata  <= '0;
         r_bus_we     <= 1'b0;
         r_bus_byteen <= '0;
         r_funct3     <= '0;
         r_lo         <= '0;
         r_data       <= '0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_bus_addr   <= {iAddress[31:2], 2'b00};
            r_bus_we     <= iMemWrite;
            r_bus_byteen <= w_byteen;
            r_bus_wdata  <= w_wdata;
            r_funct3     <= iFunct3;
            r_lo         <= iAddress[1:0];
         end
         if (w_complete && !r_bus_we) begin
            r_data <= w_load_ext;
         end else if (w_expire && !r_bus_we) begin
            r_data <= '0;
         end
      end
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_error;

   assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt   <= '0;
         r_error <= 1'b0;
      end else begin
         r_error <= w_expire;
         if (w_latch) begin
            r_cnt <= '0;
         end else if ((r_state == S_REQ) && !iBusAck) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign oError = r_error;
`else
   assign w_timeout_hit = 1'b0;
   assign oError        = 1'b0;
`endif

   assign oData       = r_data;
   assign oStall      = w_stall;
   assign oMisaligned = w_mis_pulse;
   assign oBusReq     = (r_state == S_REQ);
   assign oBusWe      = r_bus_we;
   assign oBusAddr    = r_bus_addr;
   assign oBusWData   = r_bus_wdata;
   assign oBusByteEn  = r_bus_byteen;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver queues expected transactions, negedge monitor pops and compares.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 16;
`endif

   localparam int K_ACC   = 0;
   localparam int K_MIS   = 1;
   localparam int K_ABORT = 2;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] data;
      int          stall;
      int          reqc;
      logic        err;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        iMemRead = 1'b0;
   logic        iMemWrite = 1'b0;
   logic [31:0] iAddress = '0;
   logic [31:0] iData = '0;
   logic [2:0]  iFunct3 = '0;
   logic        iBusAck = 1'b0;
   logic [31:0] iBusRData = '0;
   logic [31:0] oData;
   logic        oStall;
   logic        oMisaligned;
   logic        oError;
   logic        oBusReq;
   logic        oBusWe;
   logic [31:0] oBusAddr;
   logic [31:0] oBusWData;
   logic [3:0]  oBusByteEn;

   always #5 clock = ~clock;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clock      (clock),
      .reset      (reset),
      .iMemRead   (iMemRead),
      .iMemWrite  (iMemWrite),
      .iAddress   (iAddress),
      .iData      (iData),
      .iFunct3    (iFunct3),
      .oData      (oData),
      .oStall     (oStall),
      .oMisaligned(oMisaligned),
      .oError     (oError),
      .oBusReq    (oBusReq),
      .oBusWe     (oBusWe),
      .oBusAddr   (oBusAddr),
      .oBusWData  (oBusWData),
      .oBusByteEn (oBusByteEn),
      .iBusAck    (iBusAck),
      .iBusRData  (iBusRData)
   );

   exp_t        q[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   int          stall_cnt = 0;
   int          req_cnt = 0;
   int          wait_expired = 0;
   logic        prev_stall = 1'b0;
   logic        snap_req = 1'b0;
   logic        done_flag = 1'b0;
   logic        force_ack = 1'b0;
   logic        ack_now = 1'b0;
   int          resp_lat = 0;
   int          wcnt = 0;
   logic [31:0] resp_rdata = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // Bus slave: acks after resp_lat wait cycles of an outstanding request
   always @(posedge clock) begin
      #1;
      if (oBusReq && !reset) begin
         ack_now = (wcnt == resp_lat);
         wcnt++;
      end else begin
         ack_now = 1'b0;
         wcnt = 0;
      end
      iBusAck   = ack_now | force_ack;
      iBusRData = ack_now ? resp_rdata : 32'hBAD0_BAD0;
   end

   always @(negedge clock) begin
      if (done_flag) begin
         chk("queue_drained", q.size(), 0);
         chk("driver_waits", wait_expired, 0);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end else if (snap_req) begin
         chk("outputs_zero", {oData, oStall, oMisaligned, oError, oBusReq, oBusWe,
                              oBusAddr, oBusWData, oBusByteEn}, 0);
         prev_stall = oStall;
      end else if (reset) begin
         if (prev_stall && q.size() > 0 && q[0].kind == K_ABORT) begin
            e = q.pop_front();
            chk("abort_in_req", oBusReq, 1);
         end
         prev_stall = 1'b0;
         stall_cnt  = 0;
         req_cnt    = 0;
      end else begin
         if (oMisaligned) begin
            if (q.size() == 0) chk("unexpected_misaligned", 1, 0);
            else begin
               e = q.pop_front();
               chk("mis_kind", e.kind, K_MIS);
               chk("mis_outputs", {oStall, oBusReq, oData}, {2'b00, e.data});
            end
         end else if (oStall) begin
            stall_cnt++;
            if (oBusReq) begin
               req_cnt++;
               if (q.size() == 0) chk("unexpected_busreq", 1, 0);
               else chk("bus_fields", {oBusAddr, oBusWe, oBusByteEn, oBusWData},
                        {q[0].addr, q[0].we, q[0].be, q[0].wdata});
            end
         end else if (prev_stall) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = q.pop_front();
               chk("done_kind", e.kind, K_ACC);
               chk("done_data", oData, e.data);
               chk("stall_cycles", stall_cnt, e.stall);
               chk("req_cycles", req_cnt, e.reqc);
               chk("error_pulse", oError, e.err);
               chk("done_busreq", oBusReq, 0);
            end
            stall_cnt = 0;
            req_cnt   = 0;
         end
         prev_stall = oStall;
      end
   end

   task automatic wait_done();
      logic s;
      int   n;
      n = 0;
      do begin
         @(negedge clock);
         s = oStall;
         @(posedge clock);
         #1;
         n++;
      end while (s && n < 200);
      if (s) wait_expired++;
      iMemRead  = 1'b0;
      iMemWrite = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic run_acc(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] f3, input int lat,
                          input logic [31:0] rdata, input logic [31:0] eaddr,
                          input logic [3:0] ebe, input logic [31:0] ewdata,
                          input logic [31:0] edata, input int estall, input int ereqc,
                          input logic eerr);
      exp_t r;
      r.kind = K_ACC; r.addr = eaddr; r.we = wr; r.be = ebe; r.wdata = ewdata;
      r.data = edata; r.stall = estall; r.reqc = ereqc; r.err = eerr;
      q.push_back(r);
      resp_lat = lat; resp_rdata = rdata;
      iMemRead = rd; iMemWrite = wr; iAddress = addr; iData = data; iFunct3 = f3;
      wait_done();
   endtask

   task automatic run_mis(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] f3,
                          input logic [31:0] edata);
      exp_t r;
      r.kind = K_MIS; r.addr = '0; r.we = 1'b0; r.be = '0; r.wdata = '0;
      r.data = edata; r.stall = 0; r.reqc = 0; r.err = 1'b0;
      q.push_back(r);
      iMemRead = rd; iMemWrite = wr; iAddress = addr; iData = data; iFunct3 = f3;
      wait_done();
   endtask

   task automatic snap();
      snap_req = 1'b1;
      @(negedge clock);
      #1;
      snap_req = 1'b0;
      @(posedge clock);
      #1;
   endtask

   initial begin
      exp_t r;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      snap();

      //      rd    wr    addr          data          f3      lat rdata         bus addr      be       wdata         oData         st rq err
      run_acc(1'b1, 1'b0, 32'h0000_0100, 32'h0,        3'b010, 0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 2, 1, 1'b0);
      run_acc(1'b1, 1'b0, 32'h0000_0103, 32'h0,        3'b000, 0, 32'h80FF_00FF, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80, 2, 1, 1'b0);
      run_acc(1'b1, 1'b0, 32'h0000_0103, 32'h0,        3'b100, 0, 32'h80FF_00FF, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080, 2, 1, 1'b0);
      run_acc(1'b1, 1'b0, 32'h0000_0102, 32'h0,        3'b101, 0, 32'h80FF_00FF, 32'h0000_0100, 4'b1100, 32'h0,        32'h0000_80FF, 2, 1, 1'b0);
      run_acc(1'b0, 1'b1, 32'h0000_0206, 32'h1234_ABCD, 3'b001, 3, 32'h0,        32'h0000_0204, 4'b1100, 32'hABCD_ABCD, 32'h0000_80FF, 5, 4, 1'b0);
      run_mis(1'b1, 1'b0, 32'h0000_0101, 32'h0,        3'b010, 32'h0000_80FF);
      run_acc(1'b1, 1'b0, 32'h0000_0100, 32'h0,        3'b001, 1, 32'h0000_8001, 32'h0000_0100, 4'b0011, 32'h0,        32'hFFFF_8001, 3, 2, 1'b0);
      run_acc(1'b1, 1'b0, 32'h0000_0100, 32'h0,        3'b000, 0, 32'h1234_567F, 32'h0000_0100, 4'b0001, 32'h0,        32'h0000_007F, 2, 1, 1'b0);
      run_acc(1'b0, 1'b1, 32'h0000_0201, 32'h0000_00A5, 3'b000, 2, 32'h0,        32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 32'h0000_007F, 4, 3, 1'b0);
      run_acc(1'b0, 1'b1, 32'h0000_0200, 32'hFFFF_5A5A, 3'b101, 0, 32'h0,        32'h0000_0200, 4'b0011, 32'h5A5A_5A5A, 32'h0000_007F, 2, 1, 1'b0);
      run_acc(1'b1, 1'b0, 32'h0000_0104, 32'h0,        3'b011, 0, 32'h1122_3344, 32'h0000_0104, 4'b1111, 32'h0,        32'h1122_3344, 2, 1, 1'b0);
      run_acc(1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 3'b010, 0, 32'h0,        32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h1122_3344, 2, 1, 1'b0);
      run_mis(1'b1, 1'b0, 32'h0000_0103, 32'h0,        3'b001, 32'h1122_3344);
      run_mis(1'b0, 1'b1, 32'h0000_0202, 32'h7777_7777, 3'b010, 32'h1122_3344);
      run_acc(1'b1, 1'b0, 32'h0000_0101, 32'h0,        3'b100, 0, 32'h0000_C300, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000_00C3, 2, 1, 1'b0);
      run_acc(1'b1, 1'b0, 32'h0000_0102, 32'h0,        3'b001, 0, 32'hF00D_0000, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_F00D, 2, 1, 1'b0);

      // Reset lands in the second REQ cycle of a store that never gets acked
      r.kind = K_ABORT; r.addr = 32'h0000_0400; r.we = 1'b1; r.be = 4'b1111;
      r.wdata = 32'h55AA_55AA; r.data = '0; r.stall = 0; r.reqc = 0; r.err = 1'b0;
      q.push_back(r);
      resp_lat = 1000;
      iMemRead = 1'b0; iMemWrite = 1'b1; iAddress = 32'h0000_0400;
      iData = 32'h55AA_55AA; iFunct3 = 3'b010;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      iMemWrite = 1'b0;
      snap();
      force_ack = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      snap();
      snap();
      force_ack = 1'b0;

`ifdef LSU_TIMEOUT_EN
      run_acc(1'b1, 1'b0, 32'h0000_0504, 32'h0, 3'b010, 3,    32'hA5A5_A5A5, 32'h0000_0504, 4'b1111, 32'h0, 32'hA5A5_A5A5, 5, 4, 1'b0);
      run_acc(1'b1, 1'b0, 32'h0000_0500, 32'h0, 3'b010, 1000, 32'h0,        32'h0000_0500, 4'b1111, 32'h0, 32'h0,        5, 4, 1'b1);
`endif

      repeat (3) @(posedge clock);
      #1;
      done_flag = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle datapath's ALU/control outputs and replaces its direct data-memory access.
- Converts a datapath load/store (MemRead/MemWrite, ALU address, rs2 data, funct3) into a word-aligned, byte-enabled request/acknowledge bus transaction.
- Stalls the datapath (holds pc) until the access completes.
- Sign/zero-extends load data for the write-back mux.

Parameters:
- TIMEOUT_CYCLES, 16: bus wait limit in cycles. Used only when LSU_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- iMemRead  in  1  load request from control
- iMemWrite  in  1  store request from control
- iAddress  in  32  byte address (ALU result)
- iData  in  32  store data (rs2)
- iFunct3  in  3  access size/sign, instruction[14:12]
- oData  out  32  extended load result to write-back mux
- oStall  out  1  freeze pc/register write while 1
- oMisaligned  out  1  one-cycle pulse on misaligned access
- oError  out  1  one-cycle pulse on bus timeout (tied 0 without LSU_TIMEOUT_EN)
- oBusReq  out  1  bus request
- oBusWe  out  1  1 = write
- oBusAddr  out  32  {iAddress[31:2], 2'b00}
- oBusWData  out  32  lane-replicated store data
- oBusByteEn  out  4  byte lane enables
- iBusAck  in  1  transfer complete; iBusRData valid this cycle
- iBusRData  in  32  read data word

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - State IDLE; all outputs 0, including oData.
  - Reset mid-transaction: back to IDLE at that edge, oBusReq drops, access abandoned, no pulses.
- States: IDLE, REQ, DONE.
- IDLE:
  - If iMemRead|iMemWrite and aligned: oStall=1 combinationally this cycle. Latch bus address/we/byteen/wdata and funct3/addr[1:0]. Next state REQ.
  - If iMemWrite and iMemRead are both set, the access is a write.
  - If neither is set: oStall=0.
- REQ:
  - oBusReq=1, oStall=1.
  - Bus outputs are held stable until iBusAck.
  - On iBusAck: capture/extend iBusRData into oData (loads only), go DONE. An ack in the first REQ cycle is accepted.
- DONE:
  - oStall=0, so pc advances at the end of this cycle.
  - oBusReq=0. The still-present request is not re-triggered.
  - Next state IDLE.
- Timing:
  - Minimum access is 3 cycles with 2 stall cycles.
  - iBusAck outside REQ is ignored.
- Misaligned access:
  - Condition: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - No bus cycle, oStall=0, oMisaligned=1 for that cycle, oData unchanged, stores suppressed.
- Funct3 decode:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Other codes behave as W.
  - BU/HU on a store behave as B/H.
- Store lanes:
  - B: byteen = 1<<addr[1:0], wdata = {4{iData[7:0]}}.
  - H: byteen = addr[1] ? 1100 : 0011, wdata = {2{iData[15:0]}}.
  - W: byteen = 1111, wdata = iData.
- Load extract:
  - Byte = rdata[8*addr[1:0]+:8]; halfword = rdata[16*addr[1]+:16].
  - B/H sign-extend; BU/HU zero-extend.
- oData holds its value until the next completed load; stores leave it unchanged.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on IDLE→REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES in REQ without ack: drop oBusReq, oData=0 for loads, oError=1 for one cycle, go DONE.
  - An ack in the same cycle as expiry wins (normal completion, no error).
- Undefined:
  - No counter; REQ waits indefinitely.
  - oError is constant 0.

Test Plan:
- LW at 0x100, ack on first REQ cycle, rdata 0xDEADBEEF → oStall 1 for 2 cycles, DONE oData=0xDEADBEEF, bus addr 0x100, byteen 1111, we 0.
- LB at 0x103, rdata 0x80FF00FF → oData=0xFFFFFF80. LBU at same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SH at 0x206, iData 0x1234ABCD, ack after 3 wait cycles → oBusAddr 0x204, byteen 1100, wdata 0xABCDABCD, stable for all 4 REQ cycles, oStall 1 for 5 cycles.
- LW at 0x101 → no oBusReq, oMisaligned pulse 1 cycle, oStall 0, oData unchanged.
- Reset asserted in the 2nd REQ cycle of an SW → next cycle IDLE, all outputs 0. A later ack is ignored.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, LW with no ack → oBusReq drops after 4 REQ cycles, oError 1-cycle pulse, oData=0, stall releases in DONE.
